// File: rtl/soc_pkg.sv
// Shared definitions for the UART MMIO transmit bridge:
// address map, register offsets, STATUS layout, drain FSM states.
package soc_pkg;

  localparam logic [31:0] UART_BASE  = 32'h0200_0000;
  localparam logic [2:0]  TXDATA_OFS = 3'd0;
  localparam logic [2:0]  STATUS_OFS = 3'd4;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_CNT   = 8;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_WAIT_BUSY,
    DR_WAIT_IDLE
  } drain_e;

  function automatic logic [31:0] status_word(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic [7:0] cnt
  );
    logic [31:0] w;
    w            = '0;
    w[ST_BUSY]   = busy;
    w[ST_FULL]   = full;
    w[ST_EMPTY]  = empty;
    w[ST_CNT+:8] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio_tx_if.sv
// PicoRV32 native memory bus bundle.
// master: CPU side (request out, response in); slave: peripheral side.
interface uart_mmio_tx_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/uart_mmio_tx_fifo.sv
// fifo_sync: first-word-fall-through FIFO, sync active-low reset.
// Ports: push_i/din_i in, pop_i/dout_o out, full_o/empty_o/count_o flags.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop in the same cycle frees the slot a full push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO UART TX bridge: decodes an 8-byte window, queues bytes, drains to uart1.
// Ports: clk_48, resetn, bus (memory slave), tx_data/tx_w out, tx_busy in.
module uart_mmio_tx
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = UART_BASE,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic           clk_48,
  input  logic           resetn,
  uart_mmio_tx_if.slave  bus,
  output logic [7:0]     tx_data,
  output logic           tx_w,
  input  logic           tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  drain_e        state_q, state_d;
  logic [7:0]    txd_q, txd_d;
  logic          txw_q, txw_d;

  logic          sel, new_acc, is_wr;
  logic          is_status, is_txdata;
  logic          push_req, stall, push, pop;
  logic          f_full, f_empty;
  logic [7:0]    f_dout;
  logic [CW-1:0] f_count;
  logic [2:0]    ofs;

  wire unused_ok = &{1'b0, bus.mem_addr[1:0],
                     bus.mem_wdata[31:8]};

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_48),
    .rst_ni  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.mem_wdata[7:0]),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  assign ofs       = {bus.mem_addr[2], 2'b00};
  assign is_status = (ofs == STATUS_OFS);
  assign is_txdata = (ofs == TXDATA_OFS);
  assign is_wr     = |bus.mem_wstrb;
  assign sel       = bus.mem_valid &
                     (bus.mem_addr[31:3] == BASE_ADDR[31:3]);

  // The cycle after an ack is dead time so a held
  // mem_valid is not taken as a second access.
  assign new_acc   = sel & ~ready_q;
  assign push_req  = new_acc & is_wr & is_txdata &
                     bus.mem_wstrb[0];
  assign stall     = push_req & f_full & ~pop;
  assign push      = push_req & ~stall;

  always_comb begin
    ready_d = new_acc & ~stall;
    rdata_d = '0;
    if (ready_d && !is_wr && is_status) begin
      rdata_d = status_word(tx_busy, f_full, f_empty,
                            8'(f_count));
    end
  end

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    txw_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      DR_IDLE: begin
        if (!f_empty && !tx_busy) begin
          pop     = 1'b1;
          txd_d   = f_dout;
          txw_d   = 1'b1;
          state_d = DR_WAIT_BUSY;
        end
      end
      DR_WAIT_BUSY: begin
        if (tx_busy) state_d = DR_WAIT_IDLE;
      end
      DR_WAIT_IDLE: begin
        if (!tx_busy) state_d = DR_IDLE;
      end
      default: state_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      state_q <= DR_IDLE;
      txd_q   <= '0;
      txw_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      txd_q   <= txd_d;
      txw_q   <= txw_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign tx_data       = txd_q;
  assign tx_w          = txw_q;

endmodule
